secded_err_monitor: RTL and testbench
=====================================

// Module: secded_err_monitor
// PURPOSE
//  Sits directly downstream of the 72-bit SECDED decoder and consumes its per-word result.
//  - Counts single-bit (corrected) and double-bit (uncorrectable) errors.
//  - Captures the address of the first uncorrectable error.
//  - Queues corrected words for write-back scrubbing to memory over a REQ/ACK handshake.
//  - Raises a level interrupt when corrected errors reach a threshold.
// PARAMETERS
//  AW         32  address width of CHK_ADDR / SCRUB_ADDR / DE_ADDR
//  CW         16  width of the saturating error counters
//  DEPTH      4   scrub queue entries; power of 2, >= 2
//  SE_THRESH  8   SE_CNT value at or above which IRQ asserts; 0 disables IRQ
// PORTS
//  CLK         in   1      clock, rising edge
//  RST_N       in   1      asynchronous active-low reset
//  CHK_VALID   in   1      decoder outputs and CHK_ADDR valid this cycle
//  CHK_ADDR    in   AW     address of the word being checked, cycle-aligned with D_DATA
//  D_DATA      in   72     corrected codeword from decoder (data + check bits)
//  S_ERR       in   1      single-bit error detected and corrected
//  D_ERR       in   1      double-bit error detected, not correctable
//  CLR         in   1      synchronous clear of counters, sticky flags and IRQ
//  SCRUB_REQ   out  1      queue head valid; write SCRUB_DATA to SCRUB_ADDR
//  SCRUB_ACK   in   1      memory accepts head; pop when SCRUB_REQ & SCRUB_ACK
//  SCRUB_ADDR  out  AW     head entry address
//  SCRUB_DATA  out  72     head entry corrected codeword
//  SE_CNT      out  CW     saturating count of single-bit errors
//  DE_CNT      out  CW     saturating count of double-bit errors
//  DE_FLAG     out  1      sticky: at least one double-bit error since reset/CLR
//  DE_ADDR     out  AW     CHK_ADDR of first double-bit error since reset/CLR
//  OVF         out  1      sticky: a scrub entry was dropped because the queue was full
//  IRQ         out  1      level: SE_THRESH != 0 && SE_CNT >= SE_THRESH, or DE_FLAG
// BEHAVIOUR
//  - Reset (RST_N low, async): all outputs 0; queue emptied; head/tail/count 0. Effect is immediate.
//    SCRUB_REQ drops in the same instant, even if a handshake is in flight. The entry is lost and is not replayed.
//  - Inputs are qualified by CHK_VALID. When CHK_VALID=0, S_ERR/D_ERR/D_DATA are ignored.
//  - S_ERR & D_ERR both high is treated as a double-bit error only (no SE count, no push).
//  - Single error (CHK_VALID & S_ERR & !D_ERR) at edge N:
//    - SE_CNT increments, visible after edge N.
//    - {CHK_ADDR, D_DATA} pushes into the queue.
//    - SCRUB_REQ is high after edge N if the queue was empty: 1-cycle latency.
//  - Double error at edge N: DE_CNT increments and DE_FLAG sets.
//    - DE_ADDR loads CHK_ADDR only if DE_FLAG was 0. Later double errors do not overwrite it.
//    - No scrub push.
//  - Counters saturate at all-ones; they never wrap.
//  - Queue: DEPTH-entry circular FIFO with registered outputs from the head entry.
//    - SCRUB_REQ = !empty.
//    - While SCRUB_REQ & !SCRUB_ACK, SCRUB_ADDR/SCRUB_DATA stay stable.
//    - SCRUB_ACK while SCRUB_REQ=0 is ignored.
//    - Pointers wrap modulo DEPTH. Occupancy counter is range 0..DEPTH.
//  - Full queue:
//    - If a push coincides with a pop, both occur and occupancy is unchanged.
//    - Otherwise the push is dropped, OVF sets, and SE_CNT still increments.
//  - Empty queue with a push and no pop: head appears next cycle. A same-cycle ACK has no effect (REQ was 0).
//  - CLR (sync, edge N): SE_CNT, DE_CNT, DE_FLAG, DE_ADDR, OVF are cleared. The queue is NOT flushed.
//    - An error event in the same cycle is applied after the clear.
//    - Example: CLR & S_ERR gives SE_CNT=1. CLR & D_ERR gives DE_FLAG=1 and DE_ADDR=that address.
//  - IRQ is registered from next-state counter/flag values, so it updates on the same edge as the counters.
// TESTING
//  1. Reset, then S_ERR with CHK_ADDR=0x100 and D_DATA=72'hA5 -> next cycle: SE_CNT=1, SCRUB_REQ=1,
//     SCRUB_ADDR=0x100, SCRUB_DATA=72'hA5. Hold ACK=0 for 3 cycles: outputs stable. ACK=1 -> REQ=0 next cycle.
//  2. ACK=0; 5 S_ERR at addrs 0x10..0x14 (DEPTH=4) -> SE_CNT=5, OVF=1.
//     Drain with ACK=1: heads come out as 0x10, 0x11, 0x12, 0x13, then REQ=0.
//  3. D_ERR at 0x200, then D_ERR at 0x300 -> DE_CNT=2, DE_FLAG=1, DE_ADDR=0x200, IRQ=1, no SCRUB_REQ.
//     CLR -> all cleared, IRQ=0.
//  4. Full queue + ACK=1 + S_ERR at 0x20 in the same cycle -> occupancy stays 4, OVF=0, 0x20 becomes tail.
//     With CW=4, 20 S_ERR -> SE_CNT saturates at 15.
//  5. 8 S_ERR with ACK=1 -> IRQ rises on the edge where SE_CNT reaches 8.
//     Also: S_ERR&D_ERR together -> DE_CNT+1, SE_CNT unchanged, no push.
//  6. Two entries queued, SCRUB_REQ=1; drop RST_N mid-cycle -> SCRUB_REQ, counters and flags go to 0
//     immediately; after release the queue is empty.

Source files
------------

// File: rtl/secded_err_monitor_if.sv
// Scrub write-back channel between the SECDED error monitor (master) and memory (slave).
// Handshake: scrub_req is high while the head entry is valid; addr/data hold steady until
// scrub_ack is sampled high with scrub_req on a rising edge, which retires the entry.
interface secded_err_monitor_if #(
  parameter int AW = 32
);
  logic          scrub_req;
  logic          scrub_ack;
  logic [AW-1:0] scrub_addr;
  logic [71:0]   scrub_data;

  modport master (output scrub_req, output scrub_addr, output scrub_data, input scrub_ack);
  modport slave  (input scrub_req, input scrub_addr, input scrub_data, output scrub_ack);
endinterface

// File: rtl/secded_err_monitor.sv
// Error monitor downstream of the 72-bit SECDED decoder: saturating error counters,
// first-uncorrectable address capture, scrub write-back queue and threshold interrupt.
module secded_err_monitor #(
    parameter int AW        = 32,
    parameter int CW        = 16,
    parameter int DEPTH     = 4,
    parameter int SE_THRESH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       chk_valid_i,
    input  logic [AW-1:0]              chk_addr_i,
    input  logic [71:0]                d_data_i,
    input  logic                       s_err_i,
    input  logic                       d_err_i,
    input  logic                       clr_i,
    secded_err_monitor_if.master       scrub,
    output logic [CW-1:0]              se_cnt_o,
    output logic [CW-1:0]              de_cnt_o,
    output logic                       de_flag_o,
    output logic [AW-1:0]              de_addr_o,
    output logic                       ovf_o,
    output logic                       irq_o,
    output logic [$clog2(DEPTH):0]     q_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [CW:0]   THRESH   = (CW+1)'(SE_THRESH);

    logic [AW-1:0] mem_addr_q [DEPTH];
    logic [71:0]   mem_data_q [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic [CW-1:0] se_cnt_q, se_cnt_d, de_cnt_q, de_cnt_d;
    logic [CW-1:0] se_base, de_base;
    logic          de_flag_q, de_flag_d, flag_base;
    logic [AW-1:0] de_addr_q, de_addr_d;
    logic          ovf_q, ovf_d;
    logic          irq_q, irq_d;
    logic          se_ev, de_ev, req, pop, full, push, drop;

    always_comb begin
        // A simultaneous S_ERR and D_ERR counts as uncorrectable only.
        de_ev = chk_valid_i & d_err_i;
        se_ev = chk_valid_i & s_err_i & ~d_err_i;
        req   = (count_q != '0);
        pop   = req & scrub.scrub_ack;
        full  = (count_q == FULL_CNT);
        push  = se_ev & (~full | pop);
        drop  = se_ev & full & ~pop;

        // Clear is applied first so a same-cycle event lands on the cleared state.
        se_base   = clr_i ? '0 : se_cnt_q;
        de_base   = clr_i ? '0 : de_cnt_q;
        flag_base = clr_i ? 1'b0 : de_flag_q;

        se_cnt_d  = (se_ev && se_base != CNT_MAX) ? se_base + CW'(1) : se_base;
        de_cnt_d  = (de_ev && de_base != CNT_MAX) ? de_base + CW'(1) : de_base;
        de_flag_d = flag_base | de_ev;
        de_addr_d = clr_i ? '0 : de_addr_q;
        if (de_ev && !flag_base) de_addr_d = chk_addr_i;
        ovf_d     = (clr_i ? 1'b0 : ovf_q) | drop;

        irq_d = ((SE_THRESH != 0) && ({1'b0, se_cnt_d} >= THRESH)) || de_flag_d;

        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        if (push && !pop) count_d = count_q + (PW+1)'(1);
        if (pop && !push) count_d = count_q - (PW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            se_cnt_q  <= '0;
            de_cnt_q  <= '0;
            de_flag_q <= 1'b0;
            de_addr_q <= '0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            se_cnt_q  <= se_cnt_d;
            de_cnt_q  <= de_cnt_d;
            de_flag_q <= de_flag_d;
            de_addr_q <= de_addr_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
        end
    end

    // Payload storage needs no reset: it is only visible while the queue is non-empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr_q[tail_q] <= chk_addr_i;
            mem_data_q[tail_q] <= d_data_i;
        end
    end

    assign scrub.scrub_req  = req;
    assign scrub.scrub_addr = req ? mem_addr_q[head_q] : '0;
    assign scrub.scrub_data = req ? mem_data_q[head_q] : '0;

    assign se_cnt_o  = se_cnt_q;
    assign de_cnt_o  = de_cnt_q;
    assign de_flag_o = de_flag_q;
    assign de_addr_o = de_addr_q;
    assign ovf_o     = ovf_q;
    assign irq_o     = irq_q;
    assign q_count_o = count_q;
endmodule

// File: tb/tb_secded_err_monitor.sv
// Bench for secded_err_monitor: directed scenarios plus a randomized run against a
// queue-based reference model; a second instance with 4-bit counters covers saturation.
module tb_secded_err_monitor;
  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        chk_valid = 0;
  logic [31:0] chk_addr = '0;
  logic [71:0] d_data = '0;
  logic        s_err = 0;
  logic        d_err = 0;
  logic        clr = 0;

  logic [15:0] se_cnt, de_cnt;
  logic        de_flag, ovf, irq;
  logic [31:0] de_addr;
  logic [2:0]  q_count;

  logic [3:0]  se_cnt_s, de_cnt_s;
  logic        de_flag_s, ovf_s, irq_s;
  logic [31:0] de_addr_s;
  logic [2:0]  q_count_s;

  secded_err_monitor_if #(.AW(32)) sif ();
  secded_err_monitor_if #(.AW(32)) sif_s ();

  secded_err_monitor #(.AW(32), .CW(16), .DEPTH(DEPTH), .SE_THRESH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .chk_valid_i(chk_valid), .chk_addr_i(chk_addr),
    .d_data_i(d_data), .s_err_i(s_err), .d_err_i(d_err), .clr_i(clr), .scrub(sif.master),
    .se_cnt_o(se_cnt), .de_cnt_o(de_cnt), .de_flag_o(de_flag), .de_addr_o(de_addr),
    .ovf_o(ovf), .irq_o(irq), .q_count_o(q_count)
  );

  secded_err_monitor #(.AW(32), .CW(4), .DEPTH(DEPTH), .SE_THRESH(8)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .chk_valid_i(chk_valid), .chk_addr_i(chk_addr),
    .d_data_i(d_data), .s_err_i(s_err), .d_err_i(d_err), .clr_i(clr), .scrub(sif_s.master),
    .se_cnt_o(se_cnt_s), .de_cnt_o(de_cnt_s), .de_flag_o(de_flag_s), .de_addr_o(de_addr_s),
    .ovf_o(ovf_s), .irq_o(irq_s), .q_count_o(q_count_s)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [103:0] exp_q[$];
  int           m_se, m_se_s, m_de;
  logic         m_flag, m_ovf;
  logic [31:0]  m_daddr;

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  function automatic logic m_irq();
    return (m_se >= 8) || m_flag;
  endfunction

  function automatic logic m_irq_s();
    return (m_se_s >= 8) || m_flag;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_se = 0; m_se_s = 0; m_de = 0; m_flag = 0; m_ovf = 0; m_daddr = '0;
  endtask

  // driver: one clock with the given inputs, model advanced on the edge, outputs sampled 1ns later
  task automatic cycle(input logic v, input logic [31:0] a, input logic [71:0] d,
                       input logic s, input logic e, input logic c, input logic k);
    bit pop;
    @(negedge clk);
    chk_valid = v; chk_addr = a; d_data = d; s_err = s; d_err = e; clr = c;
    sif.scrub_ack = k; sif_s.scrub_ack = k;
    @(posedge clk);
    pop = (exp_q.size() != 0) && k;
    if (c) begin
      m_se = 0; m_se_s = 0; m_de = 0; m_flag = 0; m_ovf = 0; m_daddr = '0;
    end
    if (pop) void'(exp_q.pop_front());
    if (v && e) begin
      m_de = sat(m_de + 1, 65535);
      if (!m_flag) m_daddr = a;
      m_flag = 1;
    end else if (v && s) begin
      m_se = sat(m_se + 1, 65535);
      m_se_s = sat(m_se_s + 1, 15);
      if (exp_q.size() < DEPTH) exp_q.push_back({a, d});
      else m_ovf = 1;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic k);
    repeat (n) cycle(0, '0, '0, 0, 0, 0, k);
  endtask

  task automatic test_reset();
    total++; if (sif.scrub_req !== 1'b0) begin bad++; $display("FAIL rst_req got %0b exp 0", sif.scrub_req); end
    total++; if (se_cnt !== 16'd0) begin bad++; $display("FAIL rst_se got %0d exp 0", se_cnt); end
    total++; if (de_cnt !== 16'd0) begin bad++; $display("FAIL rst_de got %0d exp 0", de_cnt); end
    total++; if ({de_flag, ovf, irq} !== 3'b000) begin bad++; $display("FAIL rst_flags got %b exp 000", {de_flag, ovf, irq}); end
    total++; if (de_addr !== 32'd0) begin bad++; $display("FAIL rst_daddr got %0h exp 0", de_addr); end
    total++; if (sif.scrub_addr !== 32'd0 || sif.scrub_data !== 72'd0) begin bad++; $display("FAIL rst_head got %0h/%0h exp 0/0", sif.scrub_addr, sif.scrub_data); end
  endtask

  task automatic test_single();
    cycle(1, 32'h100, 72'hA5, 1, 0, 0, 0);
    total++; if (se_cnt !== 16'd1) begin bad++; $display("FAIL single_se got %0d exp 1", se_cnt); end
    total++; if (sif.scrub_req !== 1'b1) begin bad++; $display("FAIL single_req got %0b exp 1", sif.scrub_req); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (sif.scrub_addr !== 32'h100 || sif.scrub_data !== 72'hA5 || sif.scrub_req !== 1'b1) begin
        bad++; $display("FAIL single_hold%0d got %0h/%0h exp 100/a5", i, sif.scrub_addr, sif.scrub_data);
      end
      idle(1, 0);
    end
    cycle(0, '0, '0, 0, 0, 0, 1);
    total++; if (sif.scrub_req !== 1'b0) begin bad++; $display("FAIL single_pop got %0b exp 0", sif.scrub_req); end
  endtask

  task automatic test_overflow();
    cycle(0, '0, '0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 32'h10 + i, 72'(i + 7), 1, 0, 0, 0);
    total++; if (se_cnt !== 16'd5) begin bad++; $display("FAIL ovf_se got %0d exp 5", se_cnt); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got %0b exp 1", ovf); end
    total++; if (q_count !== 3'd4) begin bad++; $display("FAIL ovf_count got %0d exp 4", q_count); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sif.scrub_req !== 1'b1 || sif.scrub_addr !== 32'h10 + i) begin
        bad++; $display("FAIL ovf_drain%0d got %0h exp %0h", i, sif.scrub_addr, 32'h10 + i);
      end
      idle(1, 1);
    end
    total++; if (sif.scrub_req !== 1'b0) begin bad++; $display("FAIL ovf_empty got %0b exp 0", sif.scrub_req); end
  endtask

  task automatic test_double();
    cycle(0, '0, '0, 0, 0, 1, 0);
    cycle(1, 32'h200, 72'h1, 0, 1, 0, 0);
    cycle(1, 32'h300, 72'h2, 0, 1, 0, 0);
    total++; if (de_cnt !== 16'd2) begin bad++; $display("FAIL de_cnt got %0d exp 2", de_cnt); end
    total++; if (de_flag !== 1'b1 || irq !== 1'b1) begin bad++; $display("FAIL de_flag_irq got %b exp 11", {de_flag, irq}); end
    total++; if (de_addr !== 32'h200) begin bad++; $display("FAIL de_addr got %0h exp 200", de_addr); end
    total++; if (sif.scrub_req !== 1'b0) begin bad++; $display("FAIL de_nopush got %0b exp 0", sif.scrub_req); end
    cycle(0, '0, '0, 0, 0, 1, 0);
    total++; if ({de_cnt, de_flag, irq, ovf, de_addr} !== '0) begin bad++; $display("FAIL de_clr got %0h/%b/%0h exp 0", de_cnt, {de_flag, irq, ovf}, de_addr); end
    cycle(1, 32'h444, 72'h3, 0, 1, 1, 0);
    total++; if (de_flag !== 1'b1 || de_addr !== 32'h444 || de_cnt !== 16'd1) begin bad++; $display("FAIL de_clr_ev got %b/%0h/%0d exp 1/444/1", de_flag, de_addr, de_cnt); end
    cycle(1, 32'h555, 72'h4, 1, 0, 1, 0);
    total++; if (se_cnt !== 16'd1 || de_flag !== 1'b0) begin bad++; $display("FAIL se_clr_ev got %0d/%b exp 1/0", se_cnt, de_flag); end
    idle(2, 1);
  endtask

  task automatic test_full_pop();
    logic [31:0] order [4];
    order[0] = 32'h31; order[1] = 32'h32; order[2] = 32'h33; order[3] = 32'h20;
    cycle(0, '0, '0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 32'h30 + i, 72'(i), 1, 0, 0, 0);
    cycle(1, 32'h20, 72'h99, 1, 0, 0, 1);
    total++; if (q_count !== 3'd4) begin bad++; $display("FAIL fp_count got %0d exp 4", q_count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fp_ovf got %0b exp 0", ovf); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sif.scrub_addr !== order[i]) begin bad++; $display("FAIL fp_order%0d got %0h exp %0h", i, sif.scrub_addr, order[i]); end
      idle(1, 1);
    end
    cycle(0, '0, '0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) cycle(1, 32'h40 + i, 72'(i), 1, 0, 0, 1);
    total++; if (se_cnt_s !== 4'd15) begin bad++; $display("FAIL sat_small got %0d exp 15", se_cnt_s); end
    total++; if (se_cnt !== 16'd20) begin bad++; $display("FAIL sat_big got %0d exp 20", se_cnt); end
    idle(2, 1);
  endtask

  task automatic test_irq();
    cycle(0, '0, '0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 32'h60 + i, 72'(i), 1, 0, 0, 1);
      total++;
      if (irq !== (i == 7)) begin bad++; $display("FAIL irq_edge%0d got %0b exp %0b", i, irq, (i == 7)); end
    end
    idle(2, 1);
    cycle(1, 32'h70, 72'h5, 1, 1, 0, 0);
    total++; if (de_cnt !== 16'd1 || se_cnt !== 16'd8) begin bad++; $display("FAIL both_cnt got %0d/%0d exp 1/8", de_cnt, se_cnt); end
    total++; if (sif.scrub_req !== 1'b0) begin bad++; $display("FAIL both_nopush got %0b exp 0", sif.scrub_req); end
  endtask

  task automatic test_random();
    logic [103:0] h;
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, {$urandom, $urandom, $urandom},
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 2) == 0);
      h = (exp_q.size() != 0) ? exp_q[0] : '0;
      total++;
      if (se_cnt !== 16'(m_se) || de_cnt !== 16'(m_de) || se_cnt_s !== 4'(m_se_s)) begin
        bad++; $display("FAIL rnd_cnt n=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", n, se_cnt, de_cnt, se_cnt_s, m_se, m_de, m_se_s);
      end
      total++;
      if (de_flag !== m_flag || de_addr !== m_daddr || ovf !== m_ovf || irq !== m_irq() || irq_s !== m_irq_s()) begin
        bad++; $display("FAIL rnd_flags n=%0d got %b/%0h exp %b/%0h", n, {de_flag, ovf, irq, irq_s}, de_addr,
                        {m_flag, m_ovf, m_irq(), m_irq_s()}, m_daddr);
      end
      total++;
      if (sif.scrub_req !== (exp_q.size() != 0) || q_count !== 3'(exp_q.size()) ||
          sif.scrub_addr !== h[103:72] || sif.scrub_data !== h[71:0]) begin
        bad++; $display("FAIL rnd_queue n=%0d got %0d %0h/%0h exp %0d %0h/%0h", n, q_count, sif.scrub_addr,
                        sif.scrub_data, exp_q.size(), h[103:72], h[71:0]);
      end
    end
    idle(6, 1);
  endtask

  task automatic test_async_reset();
    cycle(0, '0, '0, 0, 0, 1, 0);
    cycle(1, 32'h80, 72'h1, 1, 0, 0, 0);
    cycle(1, 32'h81, 72'h2, 1, 0, 0, 0);
    cycle(1, 32'h82, 72'h3, 0, 1, 0, 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    total++; if (sif.scrub_req !== 1'b0) begin bad++; $display("FAIL arst_req got %0b exp 0", sif.scrub_req); end
    total++; if (se_cnt !== 16'd0 || de_cnt !== 16'd0 || de_flag !== 1'b0 || irq !== 1'b0) begin
      bad++; $display("FAIL arst_state got %0d/%0d/%b exp 0/0/00", se_cnt, de_cnt, {de_flag, irq});
    end
    @(negedge clk); rst_n = 1;
    idle(2, 0);
    total++; if (sif.scrub_req !== 1'b0 || q_count !== 3'd0) begin bad++; $display("FAIL arst_empty got %0b/%0d exp 0/0", sif.scrub_req, q_count); end
  endtask

  initial begin
    sif.scrub_ack = 0; sif_s.scrub_ack = 0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1;
    #1;
    test_reset();
    test_single();
    test_overflow();
    test_double();
    test_full_pop();
    test_irq();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
